cnn_win_addr_gen: RTL and testbench

CNN_WIN_ADDR_GEN -- requirements
Module: cnn_win_addr_gen

---
 rtl/cnn_win_addr_gen.sv | 140 ++++++++++++++
 tb/tb_cnn_win_addr_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_win_addr_gen.sv
// rtl/cnn_win_addr_gen.sv - sliding-window descriptor generator for a streamed CNN input frame
//
// Tracks how many pixels of the frame have been written (PIX_PER_WORD per
// accepted word) and issues one KxK window descriptor at a time, in row-major
// order, as soon as every pixel of that window is present in the buffer.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   frame_clr         restart the frame (clears pointer, origin, overflow)
//   wr_en             one input word accepted this cycle
//   wr_addr           pixel index where the current word is written
//   win_valid/ready   descriptor handshake
//   win_addr          top-left pixel index of the window (row*IMG_W+col)
//   win_row/win_col   window origin
//   win_last          descriptor is the final window of the frame
//   frame_done        one-cycle pulse after the final window is accepted
//   overflow          sticky: a word arrived while the frame was full
module cnn_win_addr_gen #(
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28,
  parameter int K            = 3,
  parameter int STRIDE       = 1,
  parameter int PIX_PER_WORD = 8,
  localparam int PW = $clog2(IMG_W * IMG_H + 1),
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_clr,
  input  logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [PW-1:0] win_addr,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          win_last,
  output logic          frame_done,
  output logic          overflow
);

  localparam int NPIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {S_WAIT, S_VALID, S_DONE, S_IDLE} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic [PW-1:0] room;
  logic [PW-1:0] need;
  logic [PW-1:0] origin;
  logic [31:0]   col_nxt;
  logic [31:0]   row_nxt;
  logic          col_wrap;
  logic          row_wrap;
  logic          full;

  // Every term below is bounded by NPIX for legal parameters, so PW bits
  // never wrap; the stepped origin is compared in 32 bits because col+STRIDE
  // may exceed the origin register range just before a wrap.
  always_comb begin
    room     = PW'(NPIX) - wr_ptr;
    full     = (wr_ptr == PW'(NPIX));
    need     = (PW'(row) + PW'(K - 1)) * PW'(IMG_W) + PW'(col) + PW'(K);
    origin   = PW'(row) * PW'(IMG_W) + PW'(col);
    col_nxt  = 32'(col) + 32'(STRIDE);
    row_nxt  = 32'(row) + 32'(STRIDE);
    col_wrap = (col_nxt > 32'(IMG_W - K));
    row_wrap = (row_nxt > 32'(IMG_H - K));
  end

  always_ff @(posedge clk) begin
    if (rst || frame_clr) begin
      state      <= S_WAIT;
      wr_ptr     <= '0;
      row        <= '0;
      col        <= '0;
      overflow   <= 1'b0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      win_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      // Write side runs independently of the window FSM.
      if (wr_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else if ({{(32 - PW){1'b0}}, room} <= 32'(PIX_PER_WORD)) begin
          wr_ptr <= PW'(NPIX);
        end else begin
          wr_ptr <= wr_ptr + PW'(PIX_PER_WORD);
        end
      end

      frame_done <= 1'b0;

      case (state)
        S_WAIT: begin
          // Uses the registered pointer, so valid trails the enabling write.
          if (wr_ptr >= need) begin
            state     <= S_VALID;
            win_valid <= 1'b1;
            win_addr  <= origin;
            win_last  <= col_wrap && row_wrap;
          end
        end
        S_VALID: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (win_last) begin
              // Origin is left on the final window; it is cleared by frame_clr.
              state      <= S_DONE;
              frame_done <= 1'b1;
            end else begin
              state <= S_WAIT;
              if (col_wrap) begin
                col <= '0;
                row <= RW'(row_nxt);
              end else begin
                col <= CW'(col_nxt);
              end
            end
          end
        end
        S_DONE: state <= S_IDLE;
        S_IDLE: state <= S_IDLE;
        default: state <= S_WAIT;
      endcase
    end
  end

  assign wr_addr = wr_ptr;
  assign win_row = row;
  assign win_col = col;

endmodule

// File: tb/tb_cnn_win_addr_gen.sv
// tb/tb_cnn_win_addr_gen.sv - self-checking bench for cnn_win_addr_gen (stride 1 and stride 2 instances)
module tb_cnn_win_addr_gen;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst, frame_clr, wr_en, win_ready;
  logic [9:0] wr_addr    [2];
  logic [9:0] win_addr   [2];
  logic [4:0] win_row    [2];
  logic [4:0] win_col    [2];
  logic       win_valid  [2];
  logic       win_last   [2];
  logic       frame_done [2];
  logic       overflow   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnn_win_addr_gen #(.STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .wr_en(wr_en),
    .wr_addr(wr_addr[0]), .win_valid(win_valid[0]), .win_ready(win_ready),
    .win_addr(win_addr[0]), .win_row(win_row[0]), .win_col(win_col[0]),
    .win_last(win_last[0]), .frame_done(frame_done[0]), .overflow(overflow[0])
  );

  cnn_win_addr_gen #(.STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .wr_en(wr_en),
    .wr_addr(wr_addr[1]), .win_valid(win_valid[1]), .win_ready(win_ready),
    .win_addr(win_addr[1]), .win_row(win_row[1]), .win_col(win_col[1]),
    .win_last(win_last[1]), .frame_done(frame_done[1]), .overflow(overflow[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window geometry from the frame rules: window i of a row-major scan.
  function automatic int ncols(input int s);
    return (IMG_W - K) / s + 1;
  endfunction
  function automatic int nwin(input int s);
    return ncols(s) * ((IMG_H - K) / s + 1);
  endfunction
  function automatic int w_row(input int s, input int i);
    return (i / ncols(s)) * s;
  endfunction
  function automatic int w_col(input int s, input int i);
    return (i % ncols(s)) * s;
  endfunction
  function automatic int w_need(input int s, input int i);
    return (w_row(s, i) + K - 1) * IMG_W + w_col(s, i) + K;
  endfunction

  // Behavioural model: pixels written so far, and index of the next window.
  int m_ptr = 0;
  int m_ovf = 0;
  int m_vld [2] = '{0, 0};
  int m_idx [2] = '{0, 0};
  int m_fd  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rst || frame_clr) begin
        m_vld[j] = 0; m_idx[j] = 0; m_fd[j] = 0;
      end else begin
        m_fd[j] = 0;
        if (m_vld[j] != 0) begin
          if (win_ready) begin
            m_vld[j] = 0;
            if (m_idx[j] == nwin(j + 1) - 1) m_fd[j] = 1;
            m_idx[j]++;
          end
        end else if (m_idx[j] < nwin(j + 1) && m_ptr >= w_need(j + 1, m_idx[j])) begin
          m_vld[j] = 1;
        end
      end
    end
    if (rst || frame_clr) begin
      m_ptr = 0; m_ovf = 0;
    end else if (wr_en) begin
      if (m_ptr == NPIX) m_ovf = 1;
      else m_ptr = (m_ptr + 8 > NPIX) ? NPIX : m_ptr + 8;
    end
  end

  // Observed acceptances and pulses, checked against literals.
  logic cnt_clr;
  int acc_cnt [2];
  int fd_cnt  [2];
  int last_row [2], last_col [2], last_addr [2];
  int s2_col1, s2_row13, s2_col13;

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (cnt_clr) begin
        acc_cnt[j] = 0; fd_cnt[j] = 0;
        last_row[j] = -1; last_col[j] = -1; last_addr[j] = -1;
      end else begin
        if (frame_done[j]) fd_cnt[j]++;
        if (!rst && !frame_clr && win_valid[j] && win_ready) begin
          if (j == 1 && acc_cnt[1] == 1) s2_col1 = int'(win_col[1]);
          if (j == 1 && acc_cnt[1] == 13) begin
            s2_row13 = int'(win_row[1]); s2_col13 = int'(win_col[1]);
          end
          if (win_last[j]) begin
            last_row[j] = int'(win_row[j]); last_col[j] = int'(win_col[j]);
            last_addr[j] = int'(win_addr[j]);
          end
          acc_cnt[j]++;
        end
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 2; j++) begin
        chk("wr_addr", int'(wr_addr[j]), m_ptr);
        chk("overflow", int'(overflow[j]), m_ovf);
        chk("win_valid", int'(win_valid[j]), m_vld[j]);
        chk("frame_done", int'(frame_done[j]), m_fd[j]);
        if (m_vld[j] != 0) begin
          chk("win_row", int'(win_row[j]), w_row(j + 1, m_idx[j]));
          chk("win_col", int'(win_col[j]), w_col(j + 1, m_idx[j]));
          chk("win_addr", int'(win_addr[j]),
              w_row(j + 1, m_idx[j]) * IMG_W + w_col(j + 1, m_idx[j]));
          chk("win_last", int'(win_last[j]), (m_idx[j] == nwin(j + 1) - 1) ? 1 : 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk({tag, "_valid"}, int'(win_valid[j]), 0);
      chk({tag, "_last"}, int'(win_last[j]), 0);
      chk({tag, "_done"}, int'(frame_done[j]), 0);
      chk({tag, "_ovf"}, int'(overflow[j]), 0);
      chk({tag, "_waddr"}, int'(win_addr[j]), 0);
      chk({tag, "_wraddr"}, int'(wr_addr[j]), 0);
    end
  endtask

  initial begin
    rst = 1'b1; frame_clr = 1'b0; wr_en = 1'b0; win_ready = 1'b0; cnt_clr = 1'b1;
    tick(2);
    chk_reset_vals("reset");
    rst = 1'b0; cnt_clr = 1'b0; chk_en = 1'b1;

    // Seven words: 56 pixels, first window needs 59.
    wr_en = 1'b1; tick(7); wr_en = 1'b0; tick(3);
    chk("seven_words_valid", int'(win_valid[0]), 0);
    chk("seven_words_ptr", int'(wr_addr[0]), 56);
    wr_en = 1'b1; tick(1); wr_en = 1'b0;
    chk("eighth_same_cycle", int'(win_valid[0]), 0);
    tick(1);
    chk("eighth_next_valid", int'(win_valid[0]), 1);
    chk("eighth_next_addr", int'(win_addr[0]), 0);
    chk("eighth_next_valid_s2", int'(win_valid[1]), 1);

    // Stall ten cycles: descriptor held at origin 0.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_valid", int'(win_valid[0]), 1);
      chk("stall_addr", int'(win_addr[0]), 0);
      chk("stall_rowcol", int'(win_row[0]) + int'(win_col[0]), 0);
      chk("stall_last", int'(win_last[0]), 0);
    end
    win_ready = 1'b1; tick(1); win_ready = 1'b0; tick(3);
    chk("release_acc", acc_cnt[0], 1);
    chk("release_acc_s2", acc_cnt[1], 1);

    // Rest of the frame with the consumer always ready.
    win_ready = 1'b1; wr_en = 1'b1; tick(90); wr_en = 1'b0;
    chk("full_ptr", int'(wr_addr[0]), 784);
    begin
      int budget = 4000;
      while ((fd_cnt[0] == 0 || fd_cnt[1] == 0) && budget > 0) begin
        tick(1); budget--;
      end
      chk("frame_done_timeout", (budget > 0) ? 1 : 0, 1);
    end
    tick(3);
    chk("count_s1", acc_cnt[0], 676);
    chk("count_s2", acc_cnt[1], 169);
    chk("last_row_s1", last_row[0], 25);
    chk("last_col_s1", last_col[0], 25);
    chk("last_addr_s1", last_addr[0], 725);
    chk("last_row_s2", last_row[1], 24);
    chk("last_col_s2", last_col[1], 24);
    chk("last_addr_s2", last_addr[1], 696);
    chk("done_pulses_s1", fd_cnt[0], 1);
    chk("done_pulses_s2", fd_cnt[1], 1);
    chk("s2_second_col", s2_col1, 2);
    chk("s2_row_step_row", s2_row13, 2);
    chk("s2_row_step_col", s2_col13, 0);

    // Overflow on a 99th word, then frame_clr beats a simultaneous write.
    wr_en = 1'b1; tick(1); wr_en = 1'b0;
    chk("ovf_set", int'(overflow[0]), 1);
    chk("ovf_ptr", int'(wr_addr[0]), 784);
    frame_clr = 1'b1; wr_en = 1'b1; tick(1); frame_clr = 1'b0; wr_en = 1'b0;
    chk("clr_ptr", int'(wr_addr[0]), 0);
    chk("clr_ovf", int'(overflow[0]), 0);
    chk("clr_valid", int'(win_valid[0]), 0);
    win_ready = 1'b0; wr_en = 1'b1; tick(8); wr_en = 1'b0; tick(2);
    chk("clr_refill_valid", int'(win_valid[0]), 1);
    chk("clr_refill_addr", int'(win_addr[0]), 0);

    // Reset mid-frame while a descriptor is pending; rst beats everything.
    rst = 1'b1; wr_en = 1'b1; win_ready = 1'b1; frame_clr = 1'b1; tick(1);
    rst = 1'b0; wr_en = 1'b0; win_ready = 1'b0; frame_clr = 1'b0;
    chk_reset_vals("midrst");
    wr_en = 1'b1; tick(8); wr_en = 1'b0;
    begin
      int budget = 5;
      while (!win_valid[0] && budget > 0) begin
        tick(1); budget--;
      end
      chk("post_rst_valid", int'(win_valid[0]), 1);
      chk("post_rst_addr", int'(win_addr[0]), 0);
    end
    tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
